// File: rtl/mem_pkg.sv
// Shared opcode encodings, exception codes, FSM state type and op-class
// helpers for the MEM-stage load/store engine.
package mem_pkg;

  localparam logic [7:0] EXE_LB_OP  = 8'b1110_0000;
  localparam logic [7:0] EXE_LBU_OP = 8'b1110_0100;
  localparam logic [7:0] EXE_LH_OP  = 8'b1110_0001;
  localparam logic [7:0] EXE_LHU_OP = 8'b1110_0101;
  localparam logic [7:0] EXE_LW_OP  = 8'b1110_0011;
  localparam logic [7:0] EXE_LWL_OP = 8'b1110_0010;
  localparam logic [7:0] EXE_LWR_OP = 8'b1110_0110;
  localparam logic [7:0] EXE_SB_OP  = 8'b1110_1000;
  localparam logic [7:0] EXE_SH_OP  = 8'b1110_1001;
  localparam logic [7:0] EXE_SW_OP  = 8'b1110_1011;
  localparam logic [7:0] EXE_SWL_OP = 8'b1110_1010;
  localparam logic [7:0] EXE_SWR_OP = 8'b1110_1110;
  localparam logic [7:0] EXE_LL_OP  = 8'b1111_0000;
  localparam logic [7:0] EXE_SC_OP  = 8'b1111_1000;

  localparam logic [1:0] EXC_NONE   = 2'd0;
  localparam logic [1:0] EXC_ADEL   = 2'd1;
  localparam logic [1:0] EXC_ADES   = 2'd2;
  localparam logic [1:0] EXC_BUSERR = 2'd3;

  typedef enum logic {IDLE = 1'b0, BUS = 1'b1} state_t;

  function automatic logic is_load(input logic [7:0] op);
    case (op)
      EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
      EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP, EXE_LL_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input logic [7:0] op);
    case (op)
      EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP, EXE_SC_OP: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // 0 = any address, 1 = halfword aligned, 2 = word aligned
  function automatic logic [1:0] needs_align(input logic [7:0] op);
    case (op)
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           return 2'd1;
      EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: return 2'd2;
      default:                                    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: request side builds sel/write data, response
// side extracts, extends or merges read data into the destination value.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [7:0]  req_op,
  input  logic [1:0]  req_lo,
  input  logic [31:0] req_reg2,
  output logic [3:0]  req_sel,
  output logic [31:0] req_wdata,
  input  logic [7:0]  rsp_op,
  input  logic [1:0]  rsp_lo,
  input  logic [31:0] rsp_rdata,
  input  logic [31:0] rsp_reg2,
  output logic [31:0] rsp_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // offset 0 lives in the top lane, so the extract shift is 8*(3-lo)
  assign ld_byte = 8'(rsp_rdata >> {~rsp_lo, 3'b000});
  assign ld_half = 16'(rsp_rdata >> {~rsp_lo[1], 4'b0000});

  // Request-side lane select and store data
  always_comb begin
    req_sel   = 4'b0000;
    req_wdata = 32'h0000_0000;
    case (req_op)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:           req_sel = 4'b1000 >> req_lo;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           req_sel = req_lo[1] ? 4'b0011 : 4'b1100;
      EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: req_sel = 4'b1111;
      EXE_LWL_OP, EXE_SWL_OP:                     req_sel = 4'b1111 >> req_lo;
      EXE_LWR_OP, EXE_SWR_OP:                     req_sel = 4'b1111 << ~req_lo;
      default:                                    req_sel = 4'b0000;
    endcase
    case (req_op)
      EXE_SB_OP:             req_wdata = {4{req_reg2[7:0]}};
      EXE_SH_OP:             req_wdata = {2{req_reg2[15:0]}};
      EXE_SW_OP, EXE_SC_OP:  req_wdata = req_reg2;
      EXE_SWL_OP:            req_wdata = req_reg2 >> {req_lo, 3'b000};
      EXE_SWR_OP:            req_wdata = req_reg2 << {~req_lo, 3'b000};
      default:               req_wdata = 32'h0000_0000;
    endcase
  end

  // Response-side extract / merge
  always_comb begin
    rsp_data = rsp_rdata;
    case (rsp_op)
      EXE_LB_OP:  rsp_data = {{24{ld_byte[7]}}, ld_byte};
      EXE_LBU_OP: rsp_data = {24'h00_0000, ld_byte};
      EXE_LH_OP:  rsp_data = {{16{ld_half[15]}}, ld_half};
      EXE_LHU_OP: rsp_data = {16'h0000, ld_half};
      EXE_LWL_OP: begin
        case (rsp_lo)
          2'b00:   rsp_data = rsp_rdata;
          2'b01:   rsp_data = {rsp_rdata[23:0], rsp_reg2[7:0]};
          2'b10:   rsp_data = {rsp_rdata[15:0], rsp_reg2[15:0]};
          default: rsp_data = {rsp_rdata[7:0], rsp_reg2[23:0]};
        endcase
      end
      EXE_LWR_OP: begin
        case (rsp_lo)
          2'b00:   rsp_data = {rsp_reg2[31:8], rsp_rdata[31:24]};
          2'b01:   rsp_data = {rsp_reg2[31:16], rsp_rdata[31:16]};
          2'b10:   rsp_data = {rsp_reg2[31:24], rsp_rdata[31:8]};
          default: rsp_data = rsp_rdata;
        endcase
      end
      default: rsp_data = rsp_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: request FSM, bus handshake with timeout,
// LL/SC link bit and the registered response interface.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int WAIT_MAX    = 16,
  parameter bit ALIGN_CHECK = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [7:0]        op_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              flush_i,
  input  logic              ll_clear_i,
  output logic              rsp_valid_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic [1:0]        exc_o,
  output logic              stallreq_o,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [31:0]       bus_rdata_i
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  state_t            state;
  logic              link;
  logic              flushed;
  logic [CNT_W-1:0]  wait_cnt;
  logic [7:0]        op_q;
  logic [1:0]        lo_q;
  logic [31:0]       reg2_q;
  logic              wreg_q;

  logic [ADDR_W-1:0] eaddr;
  logic [1:0]        align;
  logic              misaligned;
  logic              mem_op;
  logic              sc_fail;
  logic [3:0]        sel;
  logic [31:0]       st_data;
  logic [31:0]       ld_data;

  assign align       = needs_align(op_i);
  assign mem_op      = is_load(op_i) | is_store(op_i);
  assign sc_fail     = (op_i == EXE_SC_OP) && !link;
  assign req_ready_o = (state == IDLE);

  // Alignment check, or forced alignment when checking is disabled
  always_comb begin
    eaddr      = addr_i;
    misaligned = 1'b0;
    if (align == 2'd2) begin
      misaligned  = ALIGN_CHECK && (addr_i[1:0] != 2'b00);
      eaddr[1:0]  = ALIGN_CHECK ? addr_i[1:0] : 2'b00;
    end else if (align == 2'd1) begin
      misaligned  = ALIGN_CHECK && addr_i[0];
      eaddr[0]    = ALIGN_CHECK ? addr_i[0] : 1'b0;
    end else begin
      misaligned  = 1'b0;
    end
  end

  mem_lane_align u_lane (
    .req_op    (op_i),
    .req_lo    (eaddr[1:0]),
    .req_reg2  (reg2_i),
    .req_sel   (sel),
    .req_wdata (st_data),
    .rsp_op    (op_q),
    .rsp_lo    (lo_q),
    .rsp_rdata (bus_rdata_i),
    .rsp_reg2  (reg2_q),
    .rsp_data  (ld_data)
  );

  // Request/bus FSM with registered response and bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      link        <= 1'b0;
      flushed     <= 1'b0;
      wait_cnt    <= '0;
      op_q        <= 8'h00;
      lo_q        <= 2'b00;
      reg2_q      <= 32'h0000_0000;
      wreg_q      <= 1'b0;
      rsp_valid_o <= 1'b0;
      wd_o        <= 5'd0;
      wreg_o      <= 1'b0;
      wdata_o     <= 32'h0000_0000;
      exc_o       <= EXC_NONE;
      stallreq_o  <= 1'b0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      bus_addr_o  <= '0;
      bus_sel_o   <= 4'b0000;
      bus_wdata_o <= 32'h0000_0000;
    end else begin
      rsp_valid_o <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            op_q     <= op_i;
            lo_q     <= eaddr[1:0];
            reg2_q   <= reg2_i;
            wreg_q   <= wreg_i;
            wd_o     <= wd_i;
            flushed  <= 1'b0;
            wait_cnt <= '0;
            if (mem_op && !misaligned && !sc_fail) begin
              state       <= BUS;
              stallreq_o  <= 1'b1;
              bus_req_o   <= 1'b1;
              bus_we_o    <= is_store(op_i);
              bus_addr_o  <= {eaddr[ADDR_W-1:2], 2'b00};
              bus_sel_o   <= sel;
              bus_wdata_o <= st_data;
              if (op_i == EXE_SC_OP) begin
                link <= 1'b0;
              end
            end else begin
              rsp_valid_o <= !flush_i;
              if (!mem_op) begin
                wreg_o  <= wreg_i;
                wdata_o <= wdata_i;
                exc_o   <= EXC_NONE;
              end else if (misaligned) begin
                wreg_o  <= 1'b0;
                wdata_o <= 32'h0000_0000;
                exc_o   <= is_load(op_i) ? EXC_ADEL : EXC_ADES;
              end else begin
                wreg_o  <= wreg_i;
                wdata_o <= 32'h0000_0000;
                exc_o   <= EXC_NONE;
              end
            end
          end
        end
        BUS: begin
          if (flush_i) begin
            flushed <= 1'b1;
          end
          // error beats a simultaneous ack; timeout only when no ack arrives
          if (bus_err_i || (!bus_ack_i && (wait_cnt == CNT_W'(WAIT_MAX - 1)))) begin
            state       <= IDLE;
            stallreq_o  <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            rsp_valid_o <= !(flushed || flush_i);
            wreg_o      <= 1'b0;
            wdata_o     <= 32'h0000_0000;
            exc_o       <= EXC_BUSERR;
          end else if (bus_ack_i) begin
            state       <= IDLE;
            stallreq_o  <= 1'b0;
            bus_req_o   <= 1'b0;
            bus_we_o    <= 1'b0;
            rsp_valid_o <= !(flushed || flush_i);
            exc_o       <= EXC_NONE;
            if (op_q == EXE_SC_OP) begin
              wreg_o  <= wreg_q;
              wdata_o <= 32'h0000_0001;
            end else if (is_load(op_q)) begin
              wreg_o  <= wreg_q;
              wdata_o <= ld_data;
              if (op_q == EXE_LL_OP) begin
                link <= 1'b1;
              end
            end else begin
              wreg_o  <= 1'b0;
              wdata_o <= 32'h0000_0000;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (ll_clear_i) begin
        link <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed plus randomized bench for mem_access_unit against a byte-level
// reference model of big-endian MIPS load/store semantics.
module tb_mem_access_unit;
  import mem_pkg::*;

  localparam int WMAX = 4;
  localparam logic [7:0] ADDU_OP = 8'b0010_0001;

  logic        clk, rst, req_valid, flush, ll_clear, bus_ack, bus_err;
  logic [7:0]  op;
  logic [31:0] addr, reg2, wdata_in, bus_rdata;
  logic [4:0]  wd_in;
  logic        wreg_in;
  logic        req_ready, rsp_valid, wreg, stallreq, bus_req, bus_we;
  logic [4:0]  wd;
  logic [31:0] wdata, bus_addr, bus_wdata;
  logic [1:0]  exc;
  logic [3:0]  bus_sel;

  int vectors = 0;
  int miscompares = 0;
  int step = 0;
  bit link_m = 1'b0;

  mem_access_unit #(.ADDR_W(32), .WAIT_MAX(WMAX), .ALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .addr_i(addr), .reg2_i(reg2), .wd_i(wd_in), .wreg_i(wreg_in),
    .wdata_i(wdata_in), .flush_i(flush), .ll_clear_i(ll_clear),
    .rsp_valid_o(rsp_valid), .wd_o(wd), .wreg_o(wreg), .wdata_o(wdata),
    .exc_o(exc), .stallreq_o(stallreq), .bus_req_o(bus_req), .bus_we_o(bus_we),
    .bus_addr_o(bus_addr), .bus_sel_o(bus_sel), .bus_wdata_o(bus_wdata),
    .bus_ack_i(bus_ack), .bus_err_i(bus_err), .bus_rdata_i(bus_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s (step %0d): observed %h expected %h", tag, step, obs, exp);
    end
  endtask

  // 0 non-mem, 1 byte, 2 half, 3 word, 4 left, 5 right
  function automatic int op_class(input logic [7:0] o);
    case (o)
      EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP:           return 1;
      EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP:           return 2;
      EXE_LW_OP, EXE_SW_OP, EXE_LL_OP, EXE_SC_OP: return 3;
      EXE_LWL_OP, EXE_SWL_OP:                     return 4;
      EXE_LWR_OP, EXE_SWR_OP:                     return 5;
      default:                                    return 0;
    endcase
  endfunction

  function automatic bit op_loads(input logic [7:0] o);
    return o inside {EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                     EXE_LW_OP, EXE_LWL_OP, EXE_LWR_OP, EXE_LL_OP};
  endfunction

  // byte at address offset k of a big-endian word
  function automatic logic [7:0] byte_at(input logic [31:0] w, input int k);
    return w[31-8*k -: 8];
  endfunction

  function automatic bit touches(input int cls, input int lo, input int k);
    case (cls)
      1:       return k == lo;
      2:       return (k == lo) || (k == lo + 1);
      3:       return 1'b1;
      4:       return k >= lo;
      5:       return k <= lo;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] m_sel(input int cls, input int lo);
    logic [3:0] s = 4'b0000;
    for (int k = 0; k < 4; k++) s[3-k] = touches(cls, lo, k);
    return s;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [7:0] o, input int lo, input logic [31:0] r2);
    logic [31:0] w = 32'h0;
    case (o)
      EXE_SB_OP:            w = {4{r2[7:0]}};
      EXE_SH_OP:            w = {2{r2[15:0]}};
      EXE_SW_OP, EXE_SC_OP: w = r2;
      EXE_SWL_OP: for (int k = lo; k < 4; k++) w[31-8*k -: 8] = byte_at(r2, k - lo);
      EXE_SWR_OP: for (int k = 0; k <= lo; k++) w[31-8*k -: 8] = byte_at(r2, 3 - lo + k);
      default:              w = 32'h0;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] m_load(input logic [7:0] o, input int lo,
                                         input logic [31:0] mem, input logic [31:0] r2);
    logic [7:0]  b = byte_at(mem, lo);
    logic [15:0] h = {byte_at(mem, lo), byte_at(mem, (lo + 1) % 4)};
    logic [31:0] res = r2;
    case (o)
      EXE_LB_OP:  res = {{24{b[7]}}, b};
      EXE_LBU_OP: res = {24'h0, b};
      EXE_LH_OP:  res = {{16{h[15]}}, h};
      EXE_LHU_OP: res = {16'h0, h};
      EXE_LWL_OP: for (int j = 0; j <= 3 - lo; j++) res[31-8*j -: 8] = byte_at(mem, lo + j);
      EXE_LWR_OP: for (int j = 3 - lo; j < 4; j++) res[31-8*j -: 8] = byte_at(mem, j - 3 + lo);
      default:    res = mem;
    endcase
    return res;
  endfunction

  // One request end to end; ack_after < 0 means the bus never acks
  task automatic xact(input logic [7:0] o, input logic [31:0] a, input logic [31:0] r2,
                      input logic [31:0] rd, input int ack_after, input bit err,
                      input bit flush_bus, input bit flush_idle);
    int lo = int'(a[1:0]);
    int cls = op_class(o);
    bit ld = op_loads(o);
    bit mis = (cls == 2 && a[0]) || (cls == 3 && lo != 0);
    bit go_bus = (cls != 0) && !mis && !(o == EXE_SC_OP && !link_m);
    logic [4:0]  wdv = 5'($urandom);
    logic        wrv = 1'($urandom);
    logic [31:0] aluv = $urandom;
    logic [31:0] exp_data = 32'h0;
    logic [1:0]  exp_exc = EXC_NONE;
    logic        exp_wreg = 1'b0;
    bit exp_rsp;
    int n = 0;
    step++;
    req_valid = 1'b1; op = o; addr = a; reg2 = r2;
    wd_in = wdv; wreg_in = wrv; wdata_in = aluv; flush = flush_idle;
    check("req_ready_idle", {31'h0, req_ready}, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; flush = 1'b0; op = 8'h00;
    if (o == EXE_SC_OP && go_bus) link_m = 1'b0;
    if (go_bus) begin
      check("bus_req", {31'h0, bus_req}, 32'd1);
      check("bus_we", {31'h0, bus_we}, {31'h0, !ld});
      check("bus_addr", bus_addr, {a[31:2], 2'b00});
      check("bus_sel", {28'h0, bus_sel}, {28'h0, m_sel(cls, lo)});
      if (!ld) check("bus_wdata", bus_wdata, m_wdata(o, lo, r2));
      while (bus_req && n < 40) begin
        check("stall_in_bus", {30'h0, stallreq, req_ready}, 32'd2);
        bus_ack = (n == ack_after);
        bus_err = err && (n == ack_after);
        bus_rdata = rd;
        flush = flush_bus;
        @(posedge clk); #1;
        n++;
      end
      bus_ack = 1'b0; bus_err = 1'b0; flush = 1'b0;
      check("bus_cycles", n, (ack_after < 0) ? WMAX : ack_after + 1);
      check("stall_after", {31'h0, stallreq}, 32'd0);
      if (ack_after < 0 || err) begin
        exp_exc = EXC_BUSERR;
      end else if (o == EXE_SC_OP) begin
        exp_wreg = wrv; exp_data = 32'd1;
      end else if (ld) begin
        exp_wreg = wrv; exp_data = m_load(o, lo, rd, r2);
        if (o == EXE_LL_OP) link_m = 1'b1;
      end
    end else if (mis) begin
      check("no_bus_req", {31'h0, bus_req}, 32'd0);
      exp_exc = ld ? EXC_ADEL : EXC_ADES;
    end else if (cls != 0) begin
      check("no_bus_req", {31'h0, bus_req}, 32'd0);
      exp_wreg = wrv; exp_data = 32'd0;
    end else begin
      exp_wreg = wrv; exp_data = aluv;
    end
    exp_rsp = !(flush_idle || (go_bus && flush_bus));
    check("rsp_valid", {31'h0, rsp_valid}, {31'h0, exp_rsp});
    if (exp_rsp) begin
      check("exc", {30'h0, exc}, {30'h0, exp_exc});
      check("wreg", {31'h0, wreg}, {31'h0, exp_wreg});
      check("wd", {27'h0, wd}, {27'h0, wdv});
      if (exp_exc == EXC_NONE && (cls == 0 || ld || o == EXE_SC_OP))
        check("wdata", wdata, exp_data);
    end
    @(posedge clk); #1;
    check("rsp_pulse", {31'h0, rsp_valid}, 32'd0);
  endtask

  task automatic clear_link();
    ll_clear = 1'b1;
    @(posedge clk); #1;
    ll_clear = 1'b0;
    link_m = 1'b0;
  endtask

  logic [7:0] ops [0:14];
  logic [31:0] vals [0:2];

  initial begin
    ops = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP, EXE_LWL_OP,
            EXE_LWR_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP, EXE_SWL_OP, EXE_SWR_OP,
            EXE_LL_OP, EXE_SC_OP, ADDU_OP};
    vals = '{32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};
    rst = 1'b1; req_valid = 1'b0; flush = 1'b0; ll_clear = 1'b0;
    bus_ack = 1'b0; bus_err = 1'b0; op = 8'h00; addr = 32'h0; reg2 = 32'h0;
    wdata_in = 32'h0; bus_rdata = 32'h0; wd_in = 5'd0; wreg_in = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_ready", {31'h0, req_ready}, 32'd1);
    check("rst_outs", {29'h0, rsp_valid, stallreq, bus_req}, 32'd0);
    check("rst_data", {wdata[31:2], exc}, 32'd0);
    check("rst_bus", {bus_sel, bus_we, wreg, 26'h0}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // back-to-back pass-through ops, one response per cycle
    step++;
    req_valid = 1'b1; op = ADDU_OP; wreg_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wdata_in = vals[i]; wd_in = 5'(i + 3);
      @(posedge clk); #1;
      check("tput_valid", {31'h0, rsp_valid}, 32'd1);
      check("tput_data", wdata, vals[i]);
      check("tput_wd", {27'h0, wd}, i + 3);
    end
    req_valid = 1'b0;
    @(posedge clk); #1;

    xact(ADDU_OP, 32'h0, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b1);
    xact(EXE_LB_OP, 32'h103, 32'h0, 32'h1122_3380, 0, 1'b0, 1'b0, 1'b0);
    check("lb_value", wdata, 32'hFFFF_FF80);
    xact(EXE_LWL_OP, 32'h101, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b0, 1'b0, 1'b0);
    check("lwl_value", wdata, 32'h2233_44DD);
    xact(EXE_SWL_OP, 32'h102, 32'hAABB_CCDD, 32'h0, 1, 1'b0, 1'b0, 1'b0);
    xact(EXE_LW_OP, 32'h102, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_SH_OP, 32'h101, 32'h0, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_LW_OP, 32'h100, 32'h0, 32'h0, -1, 1'b0, 1'b0, 1'b0);
    xact(EXE_LHU_OP, 32'h102, 32'h0, 32'h1234_89AB, 3, 1'b0, 1'b0, 1'b0);
    xact(EXE_SB_OP, 32'h101, 32'h0000_005A, 32'h0, 1, 1'b1, 1'b0, 1'b0);
    xact(EXE_LL_OP, 32'h200, 32'h0, 32'hCAFE_F00D, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_SC_OP, 32'h200, 32'h1357_9BDF, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_SC_OP, 32'h200, 32'h1357_9BDF, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_LL_OP, 32'h200, 32'h0, 32'h0000_0042, 1, 1'b0, 1'b0, 1'b0);
    clear_link();
    xact(EXE_SC_OP, 32'h200, 32'h1357_9BDF, 32'h0, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_LWR_OP, 32'h302, 32'hAABB_CCDD, 32'h1122_3344, 0, 1'b0, 1'b0, 1'b0);
    xact(EXE_SWR_OP, 32'h301, 32'hAABB_CCDD, 32'h0, 0, 1'b0, 1'b0, 1'b0);

    // reset during the second bus cycle of a store
    step++;
    req_valid = 1'b1; op = EXE_SW_OP; addr = 32'h400; reg2 = 32'h0BAD_F00D;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("midrst_bus1", {31'h0, bus_req}, 32'd1);
    @(posedge clk); #1;
    check("midrst_bus2", {31'h0, bus_req}, 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; link_m = 1'b0;
    check("midrst_req", {31'h0, bus_req}, 32'd0);
    check("midrst_ready", {31'h0, req_ready}, 32'd1);
    check("midrst_rsp", {30'h0, rsp_valid, stallreq}, 32'd0);
    @(posedge clk); #1;
    check("midrst_rsp2", {31'h0, rsp_valid}, 32'd0);

    xact(EXE_SW_OP, 32'h500, 32'h7654_3210, 32'h0, 1, 1'b0, 1'b1, 1'b0);

    for (int i = 0; i < 80; i++) begin
      int r = $urandom_range(0, 9);
      if ($urandom_range(0, 7) == 0) clear_link();
      xact(ops[$urandom_range(0, 14)], $urandom & 32'h0000_0FFF, $urandom, $urandom,
           (r == 0) ? -1 : $urandom_range(0, 2), r == 1, 1'b0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
